// File: rtl/reload_decrementer_pkg.sv
// Shared state encodings and the saturating event-counter helper for the
// reload_decrementer timer.
package decrementer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Increment that sticks at max_v instead of wrapping.
    function automatic logic [31:0] evt_sat_inc(input logic [31:0] v, input logic [31:0] max_v);
        logic [31:0] r;
        if (v >= max_v) begin
            r = max_v;
        end else begin
            r = v + 32'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/reload_decrementer_if.sv
// Control/status bundle of the reload_decrementer timer; the master drives
// the controls, the slave (the timer) drives the status.
interface reload_decrementer_if #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4,
    parameter int EVT_W  = 4
);
    logic              load;
    logic [WIDTH-1:0]  load_value;
    logic              start;
    logic              stop;
    logic              decrement;
    logic [STEP_W-1:0] step;
    logic              auto_reload;
    logic              tc_clear;
    logic [WIDTH-1:0]  count;
    logic              busy;
    logic              tc_pulse;
    logic              tc_sticky;
    logic [EVT_W-1:0]  evt_count;

    modport master (
        output load, load_value, start, stop, decrement, step, auto_reload, tc_clear,
        input  count, busy, tc_pulse, tc_sticky, evt_count
    );

    modport slave (
        input  load, load_value, start, stop, decrement, step, auto_reload, tc_clear,
        output count, busy, tc_pulse, tc_sticky, evt_count
    );
endinterface

// File: rtl/reload_decrementer_step_sub.sv
// Combinational step subtractor: difference and "would reach or pass zero" flag.
module step_sub #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic [WIDTH-1:0]  count,
    input  logic [STEP_W-1:0] step,
    output logic [WIDTH-1:0]  diff,
    output logic              term
);
    logic [WIDTH-1:0] step_ext_s;

    assign step_ext_s = WIDTH'(step);
    assign diff       = count - step_ext_s;
    assign term       = (count <= step_ext_s);
endmodule

// File: rtl/reload_decrementer.sv
// Programmable down-counting timer with one-shot/auto-reload modes, a
// terminal-count pulse, sticky flag and saturating event counter.
module reload_decrementer
    import decrementer_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4,
    parameter int EVT_W  = 4
) (
    input logic                clk,
    input logic                reset,
    reload_decrementer_if.slave bus
);
    localparam logic [31:0] EVT_MAX = (32'd1 << EVT_W) - 32'd1;

    state_e            state_r, state_next_s;
    logic [WIDTH-1:0]  count_r, count_next_s;
    logic [WIDTH-1:0]  reload_r, reload_next_s;
    logic              pulse_r;
    logic              sticky_r;
    logic [EVT_W-1:0]  evt_r;
    logic [EVT_W-1:0]  evt_inc_s;
    logic [WIDTH-1:0]  diff_s;
    logic              term_s;
    logic              event_s;

    step_sub #(.WIDTH(WIDTH), .STEP_W(STEP_W)) u_step_sub (
        .count (count_r),
        .step  (bus.step),
        .diff  (diff_s),
        .term  (term_s)
    );

    assign evt_inc_s     = EVT_W'(evt_sat_inc(32'(evt_r), EVT_MAX));
    assign bus.count     = count_r;
    assign bus.busy      = (state_r == ST_RUN);
    assign bus.tc_pulse  = pulse_r;
    assign bus.tc_sticky = sticky_r;
    assign bus.evt_count = evt_r;

    // Next-state logic; load > stop > start > decrement.
    always_comb begin
        state_next_s  = state_r;
        count_next_s  = count_r;
        reload_next_s = reload_r;
        event_s       = 1'b0;
        if (bus.load) begin
            count_next_s  = bus.load_value;
            reload_next_s = bus.load_value;
            state_next_s  = ST_IDLE;
        end else if (bus.stop) begin
            if (state_r == ST_RUN) begin
                state_next_s = ST_IDLE;
            end else begin
                state_next_s = state_r;
            end
        end else if (bus.start) begin
            case (state_r)
                ST_IDLE: state_next_s = ST_RUN;
                ST_RUN:  state_next_s = ST_RUN;
                ST_DONE: begin
                    state_next_s = ST_RUN;
                    count_next_s = reload_r;
                end
                default: state_next_s = ST_IDLE;
            endcase
        end else if (bus.decrement && (state_r == ST_RUN) && (bus.step != {STEP_W{1'b0}})) begin
            if (term_s) begin
                // Terminal count never wraps below zero; mode is sampled here.
                event_s = 1'b1;
                if (bus.auto_reload) begin
                    count_next_s = reload_r;
                end else begin
                    count_next_s = {WIDTH{1'b0}};
                    state_next_s = ST_DONE;
                end
            end else begin
                count_next_s = diff_s;
            end
        end else begin
            state_next_s = state_r;
        end
    end

    // State, count and reload registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= ST_IDLE;
            count_r  <= {WIDTH{1'b0}};
            reload_r <= {WIDTH{1'b0}};
        end else begin
            state_r  <= state_next_s;
            count_r  <= count_next_s;
            reload_r <= reload_next_s;
        end
    end

    // Terminal-event status; a coincident event beats tc_clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pulse_r  <= 1'b0;
            sticky_r <= 1'b0;
            evt_r    <= {EVT_W{1'b0}};
        end else begin
            pulse_r <= event_s;
            if (event_s) begin
                sticky_r <= 1'b1;
                evt_r    <= bus.tc_clear ? EVT_W'(32'd1) : evt_inc_s;
            end else if (bus.tc_clear) begin
                sticky_r <= 1'b0;
                evt_r    <= {EVT_W{1'b0}};
            end else begin
                sticky_r <= sticky_r;
                evt_r    <= evt_r;
            end
        end
    end
endmodule
